// File: rtl/output_word_packer_pkg.sv
// Shared types and sizing for the output word packer.
package output_word_packer_pkg;

    localparam int BYTE_WIDTH     = 8;
    localparam int WORD_WIDTH     = 32;
    localparam int FRAME_WORDS    = 8;
    localparam int FIFO_DEPTH     = 4;
    localparam int FRAME_CNT_W    = 16;

    localparam int BYTES_PER_WORD = WORD_WIDTH / BYTE_WIDTH;
    // Bytes held back while a word is being assembled (all but the completing one).
    localparam int ASM_WIDTH      = WORD_WIDTH - BYTE_WIDTH;

    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int WORD_IDX_W     = $clog2(FRAME_WORDS);
    localparam int FIFO_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                  last;
        logic [WORD_WIDTH-1:0] data;
    } word_entry_t;

endpackage

// File: rtl/output_word_packer_if.sv
// Byte-in / word-out stream bundle of the packer.
interface output_word_packer_if;
    import output_word_packer_pkg::*;

    logic [BYTE_WIDTH-1:0] byte_data;
    logic                  byte_vld;
    logic                  byte_rdy;
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_last;
    logic                  word_vld;
    logic                  word_rdy;

    // Producer of bytes and consumer of words.
    modport master (
        output byte_data, byte_vld, word_rdy,
        input  byte_rdy, word_data, word_last, word_vld
    );

    // The packer itself.
    modport slave (
        input  byte_data, byte_vld, word_rdy,
        output byte_rdy, word_data, word_last, word_vld
    );
endinterface

// File: rtl/output_word_packer_word_fifo.sv
// Small synchronous FIFO of completed words with a registered head output.
module word_fifo_sync
    import output_word_packer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        enq,
    input  word_entry_t din,
    output logic        full,
    input  logic        deq,
    output logic        empty,
    output word_entry_t dout
);

    word_entry_t             mem_reg [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [FIFO_PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [FIFO_CNT_W-1:0]   count_reg, count_next;
    word_entry_t             dout_reg, dout_next;
    logic                    do_enq, do_deq;

    assign full  = (count_reg == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty = (count_reg == '0);
    assign dout  = dout_reg;

    // Next pointers, occupancy and the head entry as it will look after this edge.
    always_comb begin
        do_enq      = enq && (!full || deq);
        do_deq      = deq && !empty;
        wr_ptr_next = do_enq ? wr_ptr_reg + FIFO_PTR_W'(1) : wr_ptr_reg;
        rd_ptr_next = do_deq ? rd_ptr_reg + FIFO_PTR_W'(1) : rd_ptr_reg;
        count_next  = count_reg;
        if (do_enq && !do_deq) begin
            count_next = count_reg + FIFO_CNT_W'(1);
        end else if (!do_enq && do_deq) begin
            count_next = count_reg - FIFO_CNT_W'(1);
        end
        // A word written into the slot that becomes the head bypasses the array.
        if (do_enq && (wr_ptr_reg == rd_ptr_next)) begin
            dout_next = din;
        end else begin
            dout_next = mem_reg[rd_ptr_next];
        end
    end

    // Storage array; no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Pointer, occupancy and head register update; flush clears like reset.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            dout_reg   <= dout_next;
        end
    end

endmodule

// File: rtl/output_word_packer.sv
// Reassembles a byte stream into little-endian words, tags frame ends and buffers words.
module output_word_packer
    import output_word_packer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    output_word_packer_if.slave    bus,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    logic [BYTE_CNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [ASM_WIDTH-1:0]   asm_reg, asm_next;
    logic [WORD_IDX_W-1:0]  word_idx_reg, word_idx_next;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic                   fifo_full, fifo_empty;
    logic                   completing, byte_rdy_int, byte_fire, push, pop;
    word_entry_t            push_entry, head_entry;

    // Only the completing byte needs FIFO space, so the stall depends on registers alone.
    assign completing   = (byte_cnt_reg == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign byte_rdy_int = !completing || !fifo_full;
    assign byte_fire    = bus.byte_vld && byte_rdy_int && !clr;
    assign push         = byte_fire && completing;
    assign pop          = !fifo_empty && bus.word_rdy && !clr;

    // Earlier bytes sit in the low bits; the completing byte goes on top.
    assign push_entry = '{last: (word_idx_reg == WORD_IDX_W'(FRAME_WORDS - 1)),
                          data: {bus.byte_data, asm_reg}};

    assign bus.byte_rdy  = byte_rdy_int;
    assign bus.word_vld  = !fifo_empty;
    assign bus.word_data = head_entry.data;
    assign bus.word_last = head_entry.last;
    assign frame_cnt     = frame_cnt_reg;

    word_fifo_sync u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .enq   (push),
        .din   (push_entry),
        .full  (fifo_full),
        .deq   (pop),
        .empty (fifo_empty),
        .dout  (head_entry)
    );

    // Byte counter, assembly shift register, word index and frame counter next values.
    always_comb begin
        byte_cnt_next  = byte_cnt_reg;
        asm_next       = asm_reg;
        word_idx_next  = word_idx_reg;
        frame_cnt_next = frame_cnt_reg;
        if (byte_fire) begin
            if (completing) begin
                byte_cnt_next = '0;
                asm_next      = '0;
                word_idx_next = (word_idx_reg == WORD_IDX_W'(FRAME_WORDS - 1))
                              ? '0 : word_idx_reg + WORD_IDX_W'(1);
            end else begin
                byte_cnt_next = byte_cnt_reg + BYTE_CNT_W'(1);
                asm_next      = {bus.byte_data, asm_reg[ASM_WIDTH-1:BYTE_WIDTH]};
            end
        end
        if (pop && head_entry.last) begin
            frame_cnt_next = frame_cnt_reg + FRAME_CNT_W'(1);
        end
    end

    // Assembly state; reset clears everything, flush keeps the frame count.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_reg  <= '0;
            asm_reg       <= '0;
            word_idx_reg  <= '0;
            frame_cnt_reg <= '0;
        end else if (clr) begin
            byte_cnt_reg  <= '0;
            asm_reg       <= '0;
            word_idx_reg  <= '0;
        end else begin
            byte_cnt_reg  <= byte_cnt_next;
            asm_reg       <= asm_next;
            word_idx_reg  <= word_idx_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

endmodule

// File: tb/tb_output_word_packer.sv
// Directed bench for output_word_packer.
module tb_output_word_packer;
    import output_word_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [15:0] frame_cnt;
    int          checks = 0;
    int          errors = 0;

    output_word_packer_if ifc ();

    output_word_packer dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (ifc),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte, waits (bounded) for byte_rdy, then completes the handshake.
    task automatic send_byte(input logic [7:0] b, output int waits);
        ifc.byte_data = b;
        ifc.byte_vld  = 1'b1;
        waits = 0;
        while (ifc.byte_rdy !== 1'b1 && waits < 50) begin
            tick();
            waits++;
        end
        tick();
        ifc.byte_vld = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic l);
        $display("word %s: data=0x%08h last=%0d vld=%0d", tag, ifc.word_data, ifc.word_last, ifc.word_vld);
        chk({tag, "_vld"}, ifc.word_vld, 1'b1);
        chk({tag, "_data"}, ifc.word_data, d);
        chk({tag, "_last"}, ifc.word_last, l);
    endtask

    function automatic logic [31:0] w4(input int b);
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waits;
        int          got;
        logic [31:0] exp_q [5];

        rst = 1'b1;
        clr = 1'b0;
        ifc.byte_data = '0;
        ifc.byte_vld  = 1'b0;
        ifc.word_rdy  = 1'b0;
        tick();
        tick();
        chk("reset_byte_rdy", ifc.byte_rdy, 1'b1);
        chk("reset_word_vld", ifc.word_vld, 1'b0);
        chk("reset_word_last", ifc.word_last, 1'b0);
        chk("reset_word_data", ifc.word_data, 32'h0);
        chk("reset_frame_cnt", frame_cnt, 16'h0);
        rst = 1'b0;
        tick();

        // Single word, consumer always ready.
        ifc.word_rdy = 1'b1;
        send_byte(8'h78, waits);
        send_byte(8'h56, waits);
        send_byte(8'h34, waits);
        send_byte(8'h12, waits);
        check_word("single", 32'h12345678, 1'b0);
        tick();
        chk("single_popped", ifc.word_vld, 1'b0);
        chk("single_frame_cnt", frame_cnt, 16'h0);

        // Full frame back-to-back from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(w * 4 + k), waits);
                chk($sformatf("frame_rdy_b%0d", w * 4 + k), waits, 0);
            end
            check_word($sformatf("frame_w%0d", w), w4(w * 4), (w == 7));
        end
        chk("frame_cnt_before_pop", frame_cnt, 16'h0);
        tick();
        chk("frame_cnt_after_pop", frame_cnt, 16'h1);
        chk("frame_drained", ifc.word_vld, 1'b0);

        // Back-pressure: fill the FIFO, then 3 more bytes, then a stalled completing byte.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ifc.word_rdy = 1'b0;
        for (int i = 0; i < 19; i++) begin
            send_byte(8'(8'h40 + i), waits);
            chk($sformatf("bp_rdy_b%0d", i + 1), waits, 0);
        end
        ifc.byte_data = 8'h53;
        ifc.byte_vld  = 1'b1;
        chk("bp_stall_now", ifc.byte_rdy, 1'b0);
        tick();
        tick();
        chk("bp_stall_held", ifc.byte_rdy, 1'b0);
        check_word("bp_w1", 32'h43424140, 1'b0);
        ifc.word_rdy = 1'b1;
        tick();
        chk("bp_rdy_after_pop", ifc.byte_rdy, 1'b1);
        check_word("bp_w2", 32'h47464544, 1'b0);
        tick();
        // Byte 20 and the second pop happened together at occupancy 3.
        ifc.byte_vld = 1'b0;
        ifc.word_rdy = 1'b0;
        exp_q[0] = 32'h4B4A4948;
        exp_q[1] = 32'h4F4E4D4C;
        exp_q[2] = 32'h53525150;
        chk("bp_full_again", ifc.byte_rdy, 1'b1);
        ifc.word_rdy = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && ifc.word_vld === 1'b1 && got < 3; c++) begin
            check_word($sformatf("bp_drain%0d", got), exp_q[got], 1'b0);
            got++;
            tick();
        end
        chk("bp_drain_count", got, 3);
        chk("bp_empty", ifc.word_vld, 1'b0);
        chk("bp_frame_cnt", frame_cnt, 16'h1);

        // Flush: advance to word index 7, drop a partial word, then one clean word.
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h60 + i), waits);
            if (i == 3) check_word("pre_w5", 32'h63626160, 1'b0);
            if (i == 7) check_word("pre_w6", 32'h67666564, 1'b0);
        end
        send_byte(8'hAA, waits);
        send_byte(8'hBB, waits);
        clr = 1'b1;
        ifc.byte_data = 8'hEE;
        ifc.byte_vld  = 1'b1;
        tick();
        clr = 1'b0;
        ifc.byte_vld = 1'b0;
        send_byte(8'h01, waits);
        send_byte(8'h02, waits);
        send_byte(8'h03, waits);
        send_byte(8'h04, waits);
        check_word("flush_word", 32'h04030201, 1'b0);
        tick();
        chk("flush_frame_cnt", frame_cnt, 16'h1);
        chk("flush_empty", ifc.word_vld, 1'b0);

        // Reset mid-frame with one word still buffered.
        ifc.word_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h70 + i), waits);
        end
        ifc.word_rdy = 1'b1;
        for (int w = 0; w < 3; w++) begin
            check_word($sformatf("mid_w%0d", w), w4(8'h70 + w * 4), 1'b0);
            tick();
        end
        ifc.word_rdy = 1'b0;
        check_word("mid_buffered", w4(8'h7C), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_word_vld", ifc.word_vld, 1'b0);
        chk("mid_rst_byte_rdy", ifc.byte_rdy, 1'b1);
        chk("mid_rst_frame_cnt", frame_cnt, 16'h0);
        chk("mid_rst_word_data", ifc.word_data, 32'h0);
        ifc.word_rdy = 1'b1;
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(8'h90 + w * 4 + k), waits);
            end
            check_word($sformatf("post_w%0d", w), w4(8'h90 + w * 4), (w == 7));
        end
        tick();
        chk("post_frame_cnt", frame_cnt, 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_word_packer.md
# output_word_packer

Downstream stage of the accelerator's byte-wide result port. It accepts the OUTPUT_FIFO_WIDTH-bit rdy/vld stream and reassembles it into 32-bit IEEE-754 words. It tags the last word of each data-memory line (DATA_MEM_BW words) and buffers completed words in a small FIFO, so a word-oriented host or DMA can drain results without back-pressuring the accelerator byte by byte.

## Interface
- BYTE_WIDTH, 8: input beat width; equals the accelerator OUTPUT_FIFO_WIDTH.
- WORD_WIDTH, 32: output word width; must be a multiple of BYTE_WIDTH.
- FRAME_WORDS, 8: words per frame; equals DATA_MEM_BW (one memory line).
- FIFO_DEPTH, 4: completed-word buffer depth; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous flush; drops any partial word and all buffered words.
- byte_data  in  BYTE_WIDTH  result byte from the accelerator output_data.
- byte_vld  in  1  byte valid; driven from accelerator output_vld.
- byte_rdy  out  1  packer can accept a byte; drives accelerator output_rdy.
- word_data  out  WORD_WIDTH  head-of-FIFO word.
- word_last  out  1  head word is the final word of its frame.
- word_vld  out  1  FIFO non-empty.
- word_rdy  in  1  consumer accepts the head word.
- frame_cnt  out  16  number of frames fully dequeued since reset; wraps modulo 2^16.

## Operation
- Byte accept: a byte is accepted when byte_vld && byte_rdy.
- Byte order: little-endian. The first accepted byte of a word lands in bits [7:0], the second in [15:8], and so on.
- byte_cnt, 0..BPW-1 where BPW = WORD_WIDTH/BYTE_WIDTH, counts accepted bytes. It wraps to 0 on the completing byte.
- Push: the completing byte (byte_cnt==BPW-1) pushes {last, assembled word} into the FIFO.
  - last = (word_idx==FRAME_WORDS-1).
  - word_idx increments on each push and wraps at FRAME_WORDS-1 → 0.
- byte_rdy = (byte_cnt != BPW-1) || !fifo_full.
  - byte_rdy is derived from registered state only; there is no combinational path from word_rdy.
  - When the FIFO is full, bytes 0..BPW-2 of the next word are still accepted; the completing byte stalls.
- Pop: a word is dequeued when word_vld && word_rdy. frame_cnt increments when the dequeued word has word_last=1.
- Simultaneous push and pop: permitted at any occupancy where the push is legal. Occupancy is unchanged and order is preserved.
- clr:
  - Zeroes byte_cnt, word_idx, the assembly register and FIFO pointers/count.
  - frame_cnt is preserved.
  - A byte handshake or pop in the same cycle as clr is discarded; clr wins.
- rst: clears all state, including frame_cnt. It has priority over clr.
- A reset or clr mid-frame loses the partial frame silently. The next accepted byte starts word 0 of a new frame.

## Timing
- Reset values: byte_rdy=1, word_vld=0, word_last=0, word_data=0, frame_cnt=0.
- Latency: completing byte accepted in cycle N with the FIFO empty → word_vld=1 with that word in cycle N+1.
- Throughput: one byte per cycle sustained, i.e. one word per BPW cycles, provided the consumer drains at least one word per BPW cycles.
- word_data and word_last are stable while word_vld=1 && word_rdy=0.
- frame_cnt updates in the cycle after the last-word pop.
- byte_rdy changes only on a clock edge.

## Structure
- Shared package holds:
  - BYTES_PER_WORD = WORD_WIDTH/BYTE_WIDTH.
  - A packed struct word_entry_t {logic last; logic [WORD_WIDTH-1:0] data}.
  - Counter-width localparams via $clog2.
- Sub-module word_fifo_sync: synchronous FIFO of word_entry_t.
  - Ports: clk, rst, clr, enq/full, deq/empty, dout.
  - Registered output; supports simultaneous enq+deq when full only if deq is asserted. The packer never relies on this.
- Top level holds byte_cnt, the assembly shift register, word_idx and frame_cnt.

## Test plan
- Single word: bytes 0x78,0x56,0x34,0x12 with word_rdy=1.
  - Expect word_data=0x12345678 and word_last=0 one cycle after the 4th byte.
  - frame_cnt stays 0.
- Full frame: 32 bytes 0x00..0x1F back-to-back with word_rdy=1.
  - Expect 8 words 0x03020100 … 0x1F1E1D1C; only the 8th has word_last=1.
  - frame_cnt=1 one cycle after its pop; byte_rdy stays 1 throughout.
- Back-pressure: word_rdy=0, stream 20 bytes.
  - FIFO holds 4 words; bytes 17–19 are accepted; byte_rdy=0 with byte 20 presented.
  - Raise word_rdy: byte 20 is accepted the cycle after the first pop. All 5 words arrive in order with no loss or duplication.
- Simultaneous push/pop: occupancy 3, completing byte and pop in the same cycle.
  - Occupancy stays 3; the next words out are in order.
- Flush: 2 bytes 0xAA,0xBB, then clr, then 0x01..0x04.
  - Expect the single word 0x04030201 with word_idx restarted (word_last=0); frame_cnt unchanged.
- Reset mid-frame: after 3 words are dequeued and 1 word is buffered, assert rst for 1 cycle.
  - Expect word_vld=0, byte_rdy=1, frame_cnt=0.
  - The next frame's 8th word is the one with word_last=1.
